// File: rtl/clk_div_chk_pkg.sv
// Shared types and helpers for the divided-clock checker.
package clk_div_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // All-ones value of a counter of the given width; counters saturate here.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_chk_if.sv
// Control inputs and measurement outputs of the divided-clock checker.
interface clk_div_chk_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 8
);
  logic             en;
  logic             clr;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, clr, sig_in,
    input  period, high_cnt, period_vld, locked, err, err_cnt
  );

  modport slave (
    input  en, clr, sig_in,
    output period, high_cnt, period_vld, locked, err, err_cnt
  );
endinterface

// File: rtl/clk_div_chk_edge.sv
// Samples the divided clock under test and flags its rising edges.
// With CLK_DIV_CHK_SYNC_EN defined, sig_in first crosses a 2-flop
// synchronizer, delaying every response by two clk cycles.
module sig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic samp_src;
  logic cur_q, cur_d;    // s: current sample
  logic prev_q, prev_d;  // s_q: previous sample

  // Shift the new sample in behind the previous one
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    cur_d  = samp_src;
    prev_d = cur_q;
  end

  // Sample registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with <= so all flops see pre-edge values, independent of statement order.
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

`ifdef CLK_DIV_CHK_SYNC_EN
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Synchronizer stages ahead of the sample register
  always_comb begin
    meta_d = sig_in;
    sync_d = meta_q;
  end

  // Synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign samp_src = sync_q;
`else
  assign samp_src = sig_in;
`endif

  assign s    = cur_q;
  assign rise = cur_q & ~prev_q;

endmodule

// File: rtl/clk_div_checker.sv
// Measures period and high time of a divided clock in clk cycles, checks the
// period against EXP_PERIOD +/- TOL, and reports lock, errors and timeouts.
// Optional input synchronizer: define CLK_DIV_CHK_SYNC_EN.
module clk_div_checker
  import clk_div_chk_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_W      = 8
) (
  input logic          clk,
  input logic          rst,
  clk_div_chk_if.slave bus
);

  localparam int unsigned CW1    = CNT_W + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(sat_max(ERR_W));
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
  localparam logic [CW1-1:0]    EXP_X     = CW1'(EXP_PERIOD);
  localparam logic [CW1-1:0]    TOL_X     = CW1'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic             s, rise, active, timeout, in_tol, err_evt, cnt_evt;
  logic [CW1-1:0]   per_x, diff;

  sig_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .s      (s),
    .rise   (rise)
  );

  // Last measurement is judged in the cycle it is presented (period_vld high);
  // the difference is one bit wider than the counter so it cannot wrap.
  assign active  = (state_q != IDLE);
  assign timeout = active && !rise && (pcnt_q == CNT_MAX);
  assign per_x   = {1'b0, period_q};
  assign diff    = (per_x >= EXP_X) ? (per_x - EXP_X) : (EXP_X - per_x);
  assign in_tol  = (diff <= TOL_X);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Next state: lock after LOCK_CNT good periods, drop out on mismatch or timeout
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_evt = 1'b0;
    cnt_evt = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        TRACK: begin
          if (timeout) begin
            state_d = IDLE;
            good_d  = '0;
            err_evt = 1'b1;
            cnt_evt = 1'b1;
          end else if (vld_q) begin
            if (in_tol) begin
              good_d = good_q + GOOD_ONE;
              if (good_d == GOOD_LOCK) state_d = LOCKED;
            end else begin
              good_d  = '0;
              err_evt = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_d = IDLE;
            good_d  = '0;
            err_evt = 1'b1;
            cnt_evt = 1'b1;
          end else if (vld_q && !in_tol) begin
            state_d = TRACK;
            good_d  = '0;
            err_evt = 1'b1;
            cnt_evt = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.locked = (state_q == LOCKED);
  end

  // Counters, measurement capture and saturating error count
  always_comb begin
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    vld_d     = 1'b0;
    err_d     = err_evt;
    err_cnt_d = err_cnt_q;
    if (!bus.en) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else if (rise) begin
      pcnt_d = CNT_ONE;
      hcnt_d = CNT_ONE;
      if (active) begin
        period_d = pcnt_q;
        high_d   = hcnt_q;
        vld_d    = 1'b1;
      end
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_ONE;
      if (s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
    end
    if (bus.clr) begin
      err_cnt_d = '0;
    end else if (cnt_evt && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_cnt   = high_q;
  assign bus.period_vld = vld_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: doc/clk_div_checker.md
Name: clk_div_checker

Overview:
- Receive-side companion to the team's clock dividers.
- Samples a divided-clock signal, for example the ÷3 output, in the source clock domain.
- Measures its period and high time in source-clock cycles and compares the period against an expected value.
- Reports lock, mismatch errors and timeouts; used as an on-chip self-check of divider outputs.

Parameters:
- CNT_W, 8, width of period/high counters (saturate at 2^CNT_W-1)
- EXP_PERIOD, 3, expected period in clk cycles
- TOL, 0, allowed |period-EXP_PERIOD| deviation
- LOCK_CNT, 4, consecutive in-tolerance periods required to lock
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  source clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  enable; 0 forces IDLE and holds counters at 0
- clr  in  1  synchronous clear of err_cnt
- sig_in  in  1  divided clock under test
- period  out  CNT_W  last measured period
- high_cnt  out  CNT_W  sampled-high cycles in last period
- period_vld  out  1  one-cycle pulse when period/high_cnt update
- locked  out  1  level, period stable within tolerance
- err  out  1  one-cycle pulse on mismatch or timeout
- err_cnt  out  ERR_W  saturating count of errors while LOCKED plus timeouts

Behaviour:
- Reset: every output and internal register is 0. State is IDLE.
- Sampling: s is sig_in sampled on posedge. s_q is the previous s. rise = s & ~s_q.
- Period counter: on rise, pcnt<=1; otherwise pcnt<=pcnt+1, saturating. A rise after P cycles therefore sees pcnt==P.
- High counter: on rise, hcnt<=1; else if s, hcnt<=hcnt+1, saturating.
- Measurement: on rise in TRACK or LOCKED, the cycle after the rise has period=pcnt, high_cnt=hcnt and period_vld=1. Latency is 1 clk from the rise sample. No measurement is produced on the first rise out of IDLE.
- FSM IDLE: on rise, go to TRACK with good=0.
- FSM TRACK:
  - on a measurement in tolerance: good++. When good reaches LOCK_CNT, go to LOCKED; locked=1 from the next cycle.
  - on a measurement out of tolerance: good=0 and err pulses. err_cnt is not incremented.
- FSM LOCKED:
  - on an out-of-tolerance measurement: err pulses, err_cnt++, go to TRACK with good=0, locked drops the next cycle.
  - in-tolerance measurements: no change.
- Timeout: pcnt reaches max in TRACK or LOCKED without a rise. err pulses, err_cnt++, go to IDLE, locked=0.
- Tolerance compare uses an unsigned absolute difference, CNT_W+1 bits wide, so there is no wrap.
- Simultaneous events:
  - rise and pcnt==max in the same cycle: rise wins; measure period=max, no timeout.
  - clr and an err_cnt increment in the same cycle: clr wins, err_cnt=0.
  - err_cnt saturates at 2^ERR_W-1.
- en=0: takes effect the next cycle. FSM goes to IDLE, locked=0, and pcnt/hcnt/good are 0. period/high_cnt hold. err_cnt holds but clr still works.
- Reset mid-operation: outputs clear immediately (async). Measurement restarts from IDLE after reset deasserts.

Optional Feature:
- Macro CLK_DIV_CHK_SYNC_EN.
- When defined: sig_in passes through a 2-flop synchronizer before s, so a sig_in from an unrelated domain can be checked. Every response is 2 clk later.
- When undefined: sig_in is sampled by a single register. It must be synchronous to clk.

Decomposition:
- Shared package/include clk_div_chk_pkg holds:
  - FSM state encodings: IDLE=2'd0, TRACK=2'd1, LOCKED=2'd2.
  - Saturation helper constant for CNT_W/ERR_W maxima.
- Sub-module sig_edge_det contains the optional synchronizer, the s/s_q registers, and the rise output.
- Counters, compare, FSM and error logic stay in clk_div_checker.

Test Plan:
1. Assert rst mid-stream, async, no clk edge → all outputs 0 immediately. Deassert → IDLE, no period_vld until the second rise.
2. en=1, sig_in repeating 1 high/2 low, defaults → period_vld every 3 clks with period=3, high_cnt=1. locked=1 one cycle after the 4th measurement. err never pulses.
3. While locked, stretch one period to 4 (1 high/3 low) → period=4, err pulse, err_cnt=1, locked=0. Resume the ÷3 pattern → relock after 4 good periods.
4. While locked, hold sig_in low → timeout at pcnt=255, err pulse, err_cnt++, locked=0, FSM IDLE. The next rise gives no measurement.
5. Drive clr in the same cycle as a locked mismatch → err_cnt=0 and err still pulses. Saturation: force 300 errors with ERR_W=8 → err_cnt stays at 255.
6. With CLK_DIV_CHK_SYNC_EN defined, repeat scenario 2 → identical values, every pulse delayed by 2 clks.
